adsr_envelope: RTL and testbench

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

---
 rtl/adsr_envelope.sv | 155 +++++++++++++++
 tb/tb_adsr_envelope.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// Multi-voice ADSR envelope generator: one shared datapath sweeps the voices, one per clock, on each tick.
// Build macro ADSR_EXP_RELEASE_EN selects exponential release; otherwise release is linear.
module adsr_envelope #(
    parameter int VOICES  = 8,
    parameter int LEVEL_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tick,
    input  logic [VOICES-1:0]       gate,
    input  logic [15:0]             attack_rate,
    input  logic [15:0]             decay_rate,
    input  logic [7:0]              sustain_level,
    input  logic [15:0]             release_rate,
    output logic [VOICES-1:0][31:0] voice_volumes,
    output logic                    busy,
    output logic                    overrun
);
    localparam int SW = $clog2(VOICES);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [LEVEL_W:0] LVL_MAX = {1'b0, {LEVEL_W{1'b1}}};

    logic [VOICES-1:0][2:0]         r_state;
    logic [VOICES-1:0][LEVEL_W-1:0] r_level;
    logic [VOICES-1:0]              r_prev;
    logic [SW-1:0]                  r_slot;
    logic                           r_busy;
    logic                           r_overrun;

    logic [2:0]         w_st;
    logic [2:0]         w_phase;
    logic [2:0]         w_st_nxt;
    logic [LEVEL_W-1:0] w_lvl;
    logic [LEVEL_W-1:0] w_lvl_nxt;
    logic [LEVEL_W-1:0] w_target;
    logic [LEVEL_W:0]   w_sum;
    logic [LEVEL_W:0]   w_dec;
    logic [LEVEL_W:0]   w_step;
    logic [LEVEL_W:0]   w_rel;
    logic               w_gate;
    logic               w_rise;

    assign w_st     = r_state[r_slot];
    assign w_lvl    = r_level[r_slot];
    assign w_gate   = gate[r_slot];
    assign w_rise   = w_gate & ~r_prev[r_slot];
    assign w_target = LEVEL_W'({sustain_level, sustain_level});

    // One extra bit of headroom so saturation and underflow are visible in the MSB.
    assign w_sum = {1'b0, w_lvl} + (LEVEL_W+1)'(attack_rate);
    assign w_dec = {1'b0, w_lvl} - (LEVEL_W+1)'(decay_rate);

`ifdef ADSR_EXP_RELEASE_EN
    logic [LEVEL_W-1:0] w_shr;
    logic               w_unused_rr;
    assign w_shr       = w_lvl >> release_rate[3:0];
    assign w_step      = (w_shr == '0) ? (LEVEL_W+1)'(1) : {1'b0, w_shr};
    assign w_unused_rr = ^release_rate[15:4];
`else
    assign w_step = (LEVEL_W+1)'(release_rate);
`endif

    assign w_rel = {1'b0, w_lvl} - w_step;

    // A key press is handled as an attack update from the current level, whatever the old state.
    always_comb begin
        w_phase   = w_rise ? S_ATTACK : w_st;
        w_st_nxt  = w_st;
        w_lvl_nxt = w_lvl;
        if (!w_gate && (w_phase == S_ATTACK || w_phase == S_DECAY || w_phase == S_SUSTAIN)) begin
            w_st_nxt = S_RELEASE;
        end else begin
            case (w_phase)
                S_ATTACK: begin
                    w_st_nxt = S_ATTACK;
                    if (attack_rate != '0) begin
                        if (w_sum >= LVL_MAX) begin
                            w_lvl_nxt = LVL_MAX[LEVEL_W-1:0];
                            w_st_nxt  = S_DECAY;
                        end else begin
                            w_lvl_nxt = w_sum[LEVEL_W-1:0];
                        end
                    end
                end
                S_DECAY: begin
                    if (decay_rate != '0) begin
                        if (w_dec[LEVEL_W] || (w_dec[LEVEL_W-1:0] <= w_target)) begin
                            w_lvl_nxt = w_target;
                            w_st_nxt  = S_SUSTAIN;
                        end else begin
                            w_lvl_nxt = w_dec[LEVEL_W-1:0];
                        end
                    end
                end
                S_SUSTAIN: w_lvl_nxt = w_target;
                S_RELEASE: begin
                    if (w_step != '0) begin
                        if (w_rel[LEVEL_W] || (w_rel[LEVEL_W-1:0] == '0)) begin
                            w_lvl_nxt = '0;
                            w_st_nxt  = S_IDLE;
                        end else begin
                            w_lvl_nxt = w_rel[LEVEL_W-1:0];
                        end
                    end
                end
                default: begin
                    w_lvl_nxt = '0;
                    w_st_nxt  = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= '0;
            r_level   <= '0;
            r_prev    <= '0;
            r_slot    <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (tick) begin
                if (r_busy) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_busy <= 1'b1;
                    r_slot <= '0;
                end
            end
            if (r_busy) begin
                r_state[r_slot] <= w_st_nxt;
                r_level[r_slot] <= w_lvl_nxt;
                r_prev[r_slot]  <= w_gate;
                r_slot          <= r_slot + SW'(1);
                if (r_slot == SW'(VOICES-1))
                    r_busy <= 1'b0;
            end
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_vol
        assign voice_volumes[v] = {{(32-LEVEL_W){1'b0}}, r_level[v]};
    end

    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: expected per-voice levels are queued before each tick and
// compared by a monitor when the sweep ends.
module tb_adsr_envelope;
    localparam int VOICES = 8;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    tick;
    logic [VOICES-1:0]       gate;
    logic [15:0]             attack_rate;
    logic [15:0]             decay_rate;
    logic [7:0]              sustain_level;
    logic [15:0]             release_rate;
    logic [VOICES-1:0][31:0] voice_volumes;
    logic                    busy;
    logic                    overrun;

    always #5 clk = ~clk;

    adsr_envelope #(.VOICES(VOICES), .LEVEL_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .voice_volumes(voice_volumes), .busy(busy), .overrun(overrun)
    );

    typedef struct {
        int          v;
        logic [31:0] val;
        int          tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_x;
    logic [15:0] e[VOICES];
    int          n_pass   = 0;
    int          n_total  = 0;
    int          tag      = 0;
    int          busy_run = 0;

    // Sweep-end monitor: busy must last 8 cycles, then every queued level is compared.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            if (reset_n === 1'b1) begin
                n_total++;
                if (busy_run !== 8) $display("FAIL busy_len: got %0d cycles want 8", busy_run);
                else n_pass++;
                while (sb.size() != 0) begin
                    mon_x = sb.pop_front();
                    n_total++;
                    if (voice_volumes[mon_x.v] !== mon_x.val)
                        $display("FAIL sweep%0d_voice%0d: got %h want %h", mon_x.tag, mon_x.v,
                                 voice_volumes[mon_x.v], mon_x.val);
                    else n_pass++;
                end
            end
            busy_run = 0;
        end
    end

    task automatic expect_sweep();
        tag++;
        for (int v = 0; v < VOICES; v++) sb.push_back('{v, {16'h0, e[v]}, tag});
    endtask

    task automatic run_sweep();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        if (busy !== 1'b0) begin
            n_total++;
            $display("FAIL sweep_timeout: busy %b want 0", busy);
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick = 1'b1; gate = '1;
        attack_rate = 16'h1234; decay_rate = 16'h1; sustain_level = 8'h10; release_rate = 16'h1;
        repeat (3) @(negedge clk);
        tick = 1'b0; gate = '0;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        n_total++; if (voice_volumes !== '0) $display("FAIL reset_volumes: got %h want 0", voice_volumes); else n_pass++;
        reset_n = 1'b1;
        for (int v = 0; v < VOICES; v++) e[v] = '0;
    endtask

    task automatic test_attack();
        logic [15:0] vals[5] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hFFFF};
        gate = 8'h01; attack_rate = 16'h4000; decay_rate = '0;
        sustain_level = 8'h80; release_rate = 16'h2000;
        for (int k = 0; k < 5; k++) begin
            e[0] = vals[k];
            expect_sweep();
            run_sweep();
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_decay();
        decay_rate = 16'h1000;
        for (int k = 1; k <= 7; k++) begin
            e[0] = 16'hFFFF - 16'(k * 'h1000);
            expect_sweep(); run_sweep();
        end
        e[0] = 16'h8080; expect_sweep(); run_sweep();
        expect_sweep(); run_sweep();
        sustain_level = 8'h40; e[0] = 16'h4040; expect_sweep(); run_sweep();
        sustain_level = 8'h80; e[0] = 16'h8080; expect_sweep(); run_sweep();
    endtask

`ifdef ADSR_EXP_RELEASE_EN
    task automatic test_exp_release();
        reset_n = 1'b0; repeat (2) @(negedge clk); reset_n = 1'b1;
        for (int v = 0; v < VOICES; v++) e[v] = '0;
        gate = 8'h01; attack_rate = 16'hFFFF; decay_rate = '0; release_rate = 16'h0004;
        e[0] = 16'hFFFF; expect_sweep(); run_sweep();
        gate = 8'h00; expect_sweep(); run_sweep();
        e[0] = 16'hF000; expect_sweep(); run_sweep();
        e[0] = 16'hE100; expect_sweep(); run_sweep();
        reset_n = 1'b0; repeat (2) @(negedge clk); reset_n = 1'b1;
        gate = 8'h01; attack_rate = 16'h000F;
        e[0] = 16'h000F; expect_sweep(); run_sweep();
        gate = 8'h00; expect_sweep(); run_sweep();
        for (int k = 14; k >= 0; k--) begin
            e[0] = 16'(k); expect_sweep(); run_sweep();
        end
        e[0] = 16'h0; expect_sweep(); run_sweep();
        gate = 8'h01; attack_rate = 16'h0010; e[0] = 16'h0010; expect_sweep(); run_sweep();
    endtask
`else
    task automatic test_release();
        logic [15:0] vals[7] = '{16'h8080, 16'h6080, 16'h4080, 16'h2080, 16'h0080, 16'h0000, 16'h0000};
        gate = 8'h00; release_rate = 16'h2000;
        for (int k = 0; k < 7; k++) begin
            e[0] = vals[k];
            expect_sweep(); run_sweep();
        end
    endtask

    task automatic test_retrigger();
        gate = 8'h01; attack_rate = 16'h3000; e[0] = 16'h3000; expect_sweep(); run_sweep();
        gate = 8'h00; release_rate = 16'h0; expect_sweep(); run_sweep();
        expect_sweep(); run_sweep();
        gate = 8'h01; attack_rate = 16'h1000; e[0] = 16'h4000; expect_sweep(); run_sweep();
        e[0] = 16'h5000; expect_sweep(); run_sweep();
    endtask

    task automatic test_slot_timing();
        gate = 8'h81; e[0] = 16'h6000; e[7] = 16'h1000; expect_sweep();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL slot_busy_start: got %b want 1", busy); else n_pass++;
        n_total++; if (voice_volumes[0] !== 32'h5000) $display("FAIL slot0_early: got %h want 00005000", voice_volumes[0]); else n_pass++;
        @(negedge clk);
        n_total++; if (voice_volumes[0] !== 32'h6000) $display("FAIL slot0_after: got %h want 00006000", voice_volumes[0]); else n_pass++;
        repeat (6) @(negedge clk);
        n_total++; if (voice_volumes[7] !== 32'h0) $display("FAIL slot7_early: got %h want 00000000", voice_volumes[7]); else n_pass++;
        @(negedge clk);
        n_total++; if (voice_volumes[7] !== 32'h1000) $display("FAIL slot7_after: got %h want 00001000", voice_volumes[7]); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL slot_busy_end: got %b want 0", busy); else n_pass++;
        #1;
    endtask

    task automatic test_overrun();
        e[0] = 16'h7000; e[7] = 16'h2000; expect_sweep();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        n_total++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun); else n_pass++;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL overrun_no_restart: busy %b want 0", busy); else n_pass++;
        n_total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun); else n_pass++;
        #1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
        @(negedge clk) reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL midreset_overrun: got %b want 0", overrun); else n_pass++;
        n_total++; if (voice_volumes !== '0) $display("FAIL midreset_volumes: got %h want 0", voice_volumes); else n_pass++;
        reset_n = 1'b1;
        gate = 8'h01; attack_rate = 16'h1000;
        for (int v = 0; v < VOICES; v++) e[v] = '0;
        e[0] = 16'h1000; expect_sweep(); run_sweep();
    endtask

    task automatic test_back_to_back();
        attack_rate = 16'h8000; decay_rate = '0; release_rate = 16'h1000;
        gate = 8'hA5;
        for (int v = 0; v < VOICES; v++) e[v] = gate[v] ? 16'h8000 : 16'h0000;
        e[0] = 16'h9000; expect_sweep(); run_sweep();
        gate = 8'h5A;
        for (int v = 0; v < VOICES; v++) e[v] = 16'h8000;
        e[0] = 16'h9000; expect_sweep(); run_sweep();
        for (int v = 0; v < VOICES; v++) e[v] = gate[v] ? 16'hFFFF : 16'h7000;
        e[0] = 16'h8000; expect_sweep(); run_sweep();
    endtask
`endif

    initial begin
        test_reset();
        test_attack();
        test_decay();
`ifdef ADSR_EXP_RELEASE_EN
        test_exp_release();
`else
        test_release();
        test_retrigger();
        test_slot_timing();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
`endif
        repeat (2) @(negedge clk);
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
